// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit counters,
// a return address stack trained at execute, and mispredict statistics.
module branch_predictor #(
  parameter int DATAW     = 32,
  parameter int ENTRIES   = 16,
  parameter int IDXW      = $clog2(ENTRIES),
  parameter int TAGW      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int CNTW      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [DATAW-1:0] f_pc,
  output logic             f_pred_taken,
  output logic [DATAW-1:0] f_pred_target,
  input  logic             upd_valid,
  input  logic [DATAW-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [DATAW-1:0] upd_target,
  input  logic             upd_is_jump,
  input  logic             upd_is_call,
  input  logic             upd_is_ret,
  input  logic             upd_mispredict,
  output logic [CNTW-1:0]  cnt_updates,
  output logic [CNTW-1:0]  cnt_mispredicts
);

  localparam int RPW = $clog2(RAS_DEPTH);
  localparam logic [RPW:0] RAS_FULL = (RPW+1)'(RAS_DEPTH);

  logic             valid_q  [ENTRIES];
  logic [TAGW-1:0]  tag_q    [ENTRIES];
  logic [DATAW-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic             kind_q   [ENTRIES];

  logic [DATAW-1:0] ras_mem  [RAS_DEPTH];
  logic [RPW-1:0]   ras_ptr;
  logic [RPW:0]     ras_cnt;
  logic [RPW-1:0]   ras_top_idx;
  logic [DATAW-1:0] ras_top;

  logic [IDXW-1:0]  f_idx, u_idx;
  logic [TAGW-1:0]  f_tag, u_tag;
  logic             f_hit, u_hit;
  logic [DATAW-1:0] ret_addr;

  assign f_idx       = f_pc[IDXW+1:2];
  assign f_tag       = f_pc[IDXW+2+TAGW-1:IDXW+2];
  assign u_idx       = upd_pc[IDXW+1:2];
  assign u_tag       = upd_pc[IDXW+2+TAGW-1:IDXW+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign ret_addr    = upd_pc + DATAW'(4);
  // ras_ptr names the next free slot, so the top lives one below it
  assign ras_top_idx = ras_ptr - 1'b1;
  assign ras_top     = ras_mem[ras_top_idx];

  always_comb begin
    f_pred_taken  = 1'b0;
    f_pred_target = f_pc + DATAW'(4);
    if (f_hit) begin
      if (kind_q[f_idx]) begin
        f_pred_taken  = 1'b1;
        f_pred_target = (ras_cnt != '0) ? ras_top : target_q[f_idx];
      end else begin
        f_pred_taken  = ctr_q[f_idx][1];
        f_pred_target = target_q[f_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
      ras_ptr         <= '0;
      ras_cnt         <= '0;
      cnt_updates     <= '0;
      cnt_mispredicts <= '0;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (upd_valid) begin
      cnt_updates <= cnt_updates + 1'b1;
      if (upd_mispredict) cnt_mispredicts <= cnt_mispredicts + 1'b1;

      if (u_hit) begin
        if (upd_is_jump) begin
          ctr_q[u_idx]    <= 2'b11;
          target_q[u_idx] <= upd_target;
          kind_q[u_idx]   <= upd_is_ret;
        end else if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          target_q[u_idx] <= upd_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= upd_is_jump ? 2'b11 : 2'b10;
        kind_q[u_idx]   <= upd_is_ret;
      end

      // call+ret on a non-empty stack is a pop followed by a push: replace the top
      if (upd_is_call && upd_is_ret && ras_cnt != '0) begin
        ras_mem[ras_top_idx] <= ret_addr;
      end else if (upd_is_call) begin
        ras_mem[ras_ptr] <= ret_addr;
        ras_ptr          <= ras_ptr + 1'b1;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (upd_is_ret && ras_cnt != '0) begin
        ras_ptr <= ras_top_idx;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic,
// all checked against an abstract BTB/RAS/counter model held in the bench.
module tb_branch_predictor;

  localparam int ENTRIES   = 16;
  localparam int TAGN      = 256;
  localparam int RAS_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, clear;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        upd_valid, upd_taken, upd_is_jump, upd_is_call, upd_is_ret, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] cnt_updates, cnt_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor dut (
    .clock(clock), .reset(reset), .clear(clear), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump), .upd_is_call(upd_is_call),
    .upd_is_ret(upd_is_ret), .upd_mispredict(upd_mispredict),
    .cnt_updates(cnt_updates), .cnt_mispredicts(cnt_mispredicts)
  );

  always #5 clock = ~clock;

  // Reference model: a table of entries indexed by word address, a queue as the stack.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          m_kind   [ENTRIES];
  logic [31:0] m_ras [$];
  logic [31:0] m_cnt_upd, m_cnt_mis;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % TAGN;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    int i = m_idx(pc);
    t = 1'b0;
    tgt = pc + 32'd4;
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (m_kind[i]) begin
        t = 1'b1;
        tgt = (m_ras.size() > 0) ? m_ras[$] : m_target[i];
      end else begin
        t = (m_ctr[i] >= 2);
        tgt = m_target[i];
      end
    end
  endfunction

  function automatic void model_clock();
    int i;
    bit hit;
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 0; m_ctr[k] = 0; end
      m_ras.delete();
      m_cnt_upd = 0;
      m_cnt_mis = 0;
    end else if (clear) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      m_ras.delete();
    end else if (upd_valid) begin
      m_cnt_upd = m_cnt_upd + 1;
      if (upd_mispredict) m_cnt_mis = m_cnt_mis + 1;
      i = m_idx(upd_pc);
      hit = m_valid[i] && m_tag[i] == m_tagof(upd_pc);
      if (hit && upd_is_jump) begin
        m_ctr[i] = 3; m_target[i] = upd_target; m_kind[i] = upd_is_ret;
      end else if (hit) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_target[i] = upd_target;
        m_ctr[i] = upd_is_jump ? 3 : 2; m_kind[i] = upd_is_ret;
      end
      if (upd_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (upd_is_call) begin
        m_ras.push_back(upd_pc + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic set_idle();
    reset = 0; clear = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_is_jump = 0; upd_is_call = 0; upd_is_ret = 0; upd_mispredict = 0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                         input bit jump, input bit call, input bit ret, input bit mis);
    upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    upd_is_jump = jump; upd_is_call = call; upd_is_ret = ret; upd_mispredict = mis;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    f_pc = 32'h0100_0000;
    tick(); tick();
    reset = 0;
    #1;
    n_checks++; if (f_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %0b want 0", f_pred_taken); end
    n_checks++; if (f_pred_target !== 32'h0100_0004) begin n_fail++; $display("FAIL reset_target: got %h want 01000004", f_pred_target); end
    n_checks++; if (cnt_updates !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_updates: got %0d want 0", cnt_updates); end
    n_checks++; if (cnt_mispredicts !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_mispredicts: got %0d want 0", cnt_mispredicts); end
    f_pc = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (f_pred_target !== 32'h0000_0000) begin n_fail++; $display("FAIL pc_wrap_target: got %h want 00000000", f_pred_target); end
  endtask

  task automatic test_branch_counter();
    bit ups  [5] = '{0, 0, 0, 1, 1};
    bit exps [5] = '{0, 0, 0, 0, 1};
    f_pc = 32'h0100_0010;
    set_upd(32'h0100_0010, 1, 32'h0100_0040, 0, 0, 0, 0);
    #1;
    n_checks++; if (f_pred_taken !== 1'b0) begin n_fail++; $display("FAIL alloc_before: got %0b want 0", f_pred_taken); end
    tick();
    set_idle();
    #1;
    n_checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h0100_0040) begin
      n_fail++; $display("FAIL alloc_after: got %0b/%h want 1/01000040", f_pred_taken, f_pred_target); end
    for (int k = 0; k < 5; k++) begin
      set_upd(32'h0100_0010, ups[k], 32'h0100_0040, 0, 0, 0, 0);
      tick();
      set_idle();
      #1;
      n_checks++; if (f_pred_taken !== exps[k] || f_pred_target !== 32'h0100_0040) begin
        n_fail++; $display("FAIL ctr_step%0d: got %0b/%h want %0b/01000040", k, f_pred_taken, f_pred_target, exps[k]); end
    end
  endtask

  task automatic test_aliasing();
    set_upd(32'h0100_0050, 1, 32'h0100_0090, 0, 0, 0, 0);
    tick();
    set_idle();
    f_pc = 32'h0100_0010;
    #1;
    n_checks++; if (f_pred_taken !== 1'b0 || f_pred_target !== 32'h0100_0014) begin
      n_fail++; $display("FAIL alias_old: got %0b/%h want 0/01000014", f_pred_taken, f_pred_target); end
    f_pc = 32'h0100_0050;
    #1;
    n_checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h0100_0090) begin
      n_fail++; $display("FAIL alias_new: got %0b/%h want 1/01000090", f_pred_taken, f_pred_target); end
  endtask

  task automatic test_ras();
    logic [31:0] want;
    set_idle();
    clear = 1;
    tick();
    clear = 0;
    set_upd(32'h0100_0804, 1, 32'h0100_0ABC, 1, 0, 1, 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      set_upd(32'(i * 32'h100), 1, 32'h0000_2000, 1, 1, 0, 0);
      tick();
    end
    f_pc = 32'h0100_0804;
    for (int k = 0; k < 5; k++) begin
      set_upd(32'h0100_0804, 1, 32'h0100_0ABC, 1, 0, 1, 0);
      want = (k < 4) ? 32'(32'h504 - k * 32'h100) : 32'h0100_0ABC;
      #1;
      n_checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== want) begin
        n_fail++; $display("FAIL ras_pop%0d: got %0b/%h want 1/%h", k, f_pred_taken, f_pred_target, want); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_same_cycle_and_clear();
    logic [31:0] pcs [5] = '{32'h0100_0010, 32'h0100_0050, 32'h0100_0020, 32'h0100_0804, 32'h0100_0030};
    logic [31:0] upd_before;
    f_pc = 32'h0100_0020;
    set_upd(32'h0100_0020, 1, 32'h0100_0300, 0, 0, 0, 0);
    #1;
    n_checks++; if (f_pred_taken !== 1'b0 || f_pred_target !== 32'h0100_0024) begin
      n_fail++; $display("FAIL rdw_old: got %0b/%h want 0/01000024", f_pred_taken, f_pred_target); end
    tick();
    set_idle();
    #1;
    n_checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h0100_0300) begin
      n_fail++; $display("FAIL rdw_new: got %0b/%h want 1/01000300", f_pred_taken, f_pred_target); end
    upd_before = m_cnt_upd;
    set_upd(32'h0100_0030, 1, 32'h0000_5000, 1, 0, 0, 1);
    clear = 1;
    tick();
    set_idle();
    #1;
    n_checks++; if (cnt_updates !== upd_before) begin
      n_fail++; $display("FAIL clear_cnt: got %0d want %0d", cnt_updates, upd_before); end
    for (int k = 0; k < 5; k++) begin
      f_pc = pcs[k];
      #1;
      n_checks++; if (f_pred_taken !== 1'b0 || f_pred_target !== pcs[k] + 32'd4) begin
        n_fail++; $display("FAIL clear_miss%0d: got %0b/%h want 0/%h", k, f_pred_taken, f_pred_target, pcs[k] + 32'd4); end
    end
  endtask

  task automatic test_counters();
    set_idle();
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      set_upd(32'h0200_0000 + 32'(k * 4), 0, 0, 0, 0, 0, (k == 2 || k == 5 || k == 7));
      tick();
    end
    set_idle();
    #1;
    n_checks++; if (cnt_updates !== 32'd10) begin n_fail++; $display("FAIL cnt_updates10: got %0d want 10", cnt_updates); end
    n_checks++; if (cnt_mispredicts !== 32'd3) begin n_fail++; $display("FAIL cnt_mis3: got %0d want 3", cnt_mispredicts); end
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h0200_0100, 1, 32'h0200_0200, 0, 0, 0, 1);
      tick();
    end
    reset = 1;
    tick();
    set_idle();
    #1;
    n_checks++; if (cnt_updates !== 32'd0 || cnt_mispredicts !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", cnt_updates, cnt_mispredicts); end
    f_pc = 32'h0200_0100;
    #1;
    n_checks++; if (f_pred_taken !== 1'b0) begin n_fail++; $display("FAIL mid_reset_miss: got %0b want 0", f_pred_taken); end
  endtask

  function automatic logic [31:0] pool_pc();
    return 32'h0100_0000 + 32'($urandom_range(0, 1) << 6) + 32'($urandom_range(0, 7) << 2);
  endfunction

  task automatic test_random();
    logic        et;
    logic [31:0] etgt;
    for (int n = 0; n < 600; n++) begin
      set_idle();
      f_pc = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool_pc();
      if ($urandom_range(0, 9) < 7) begin
        upd_is_jump = ($urandom_range(0, 2) == 0);
        set_upd(pool_pc(), upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                upd_is_jump, upd_is_jump && $urandom_range(0, 2) == 0,
                upd_is_jump && $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      end
      clear = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 199) == 0);
      model_lookup(f_pc, et, etgt);
      #1;
      n_checks++; if (f_pred_taken !== et || f_pred_target !== etgt) begin
        n_fail++; $display("FAIL rand_pred@%0d pc=%h: got %0b/%h want %0b/%h", n, f_pc, f_pred_taken, f_pred_target, et, etgt); end
      n_checks++; if (cnt_updates !== m_cnt_upd || cnt_mispredicts !== m_cnt_mis) begin
        n_fail++; $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", n, cnt_updates, cnt_mispredicts, m_cnt_upd, m_cnt_mis); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    f_pc = 0;
    test_reset();
    test_branch_counter();
    test_aliasing();
    test_ras();
    test_same_cycle_and_clear();
    test_counters();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
